// File: rtl/calc_key_frontend.sv
// Calculator key front end: each of four raw buttons is synchronised, debounced and edge-detected, and the
// resulting press is issued as an op command over valid/ready. Defining KEY_REPEAT_EN adds auto-repeat for add/sub/mul.
module calc_key_frontend #(
   parameter int unsigned DEB_CYCLES    = 32'd1000000,
   parameter int unsigned REPEAT_DELAY  = 32'd25000000,
   parameter int unsigned REPEAT_PERIOD = 32'd10000000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       key_clr_i,
   input  logic       key_add_i,
   input  logic       key_sub_i,
   input  logic       key_mul_i,
   input  logic       cmd_ready_i,
   output logic       cmd_valid_o,
   output logic [1:0] cmd_op_o,
   output logic [1:0] op_cur_o,
   output logic [3:0] key_state_o,
   output logic       overrun_o,
   output logic       multi_o
);

   localparam int unsigned DCW = $clog2(DEB_CYCLES);
   localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 32'd1);

   function automatic logic multi_hot(input logic [3:0] v);
      return (v & (v - 4'd1)) != 4'd0;
   endfunction

   logic [3:0]     raw_s;
   logic [3:0]     sync1_q, sync2_q, key_state_q, key_prev_q, key_state_d;
   logic [DCW-1:0] deb_cnt_q [4];
   logic [DCW-1:0] deb_cnt_d [4];
   logic [3:0]     press_s, ev_s;
   logic           any_ev_s, accept_s;
   logic [1:0]     enc_op_s;
   logic           cmd_valid_q, cmd_valid_d, overrun_q, overrun_d, multi_q, multi_d;
   logic [1:0]     cmd_op_q, cmd_op_d, op_cur_q, op_cur_d;

   assign raw_s   = {key_mul_i, key_sub_i, key_add_i, key_clr_i};
   assign press_s = key_state_q & ~key_prev_q;

   // Per-key debounce: a mismatch must persist DEB_CYCLES edges before the level flips
   always_comb begin
      key_state_d = key_state_q;
      for (int i = 0; i < 4; i++) begin
         deb_cnt_d[i] = deb_cnt_q[i];
         if (sync2_q[i] == key_state_q[i]) begin
            deb_cnt_d[i] = '0;
         end else if (deb_cnt_q[i] == DEB_LAST) begin
            deb_cnt_d[i]   = '0;
            key_state_d[i] = ~key_state_q[i];
         end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + DCW'(1);
         end
      end
   end

`ifdef KEY_REPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RCW = $clog2(REP_MAX);
   localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 32'd1);
   localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 32'd1);

   logic [3:0]     rep_key_s, rep_prev_q, rep_prev_d;
   logic [RCW-1:0] rep_cnt_q, rep_cnt_d;
   logic           rep_first_q, rep_first_d, rep_fire_s;

   // Repeat timer follows the highest-priority held add/sub/mul key and restarts whenever that key changes
   always_comb begin
      if (key_state_q[1]) begin
         rep_key_s = 4'b0010;
      end else if (key_state_q[2]) begin
         rep_key_s = 4'b0100;
      end else if (key_state_q[3]) begin
         rep_key_s = 4'b1000;
      end else begin
         rep_key_s = 4'b0000;
      end
      rep_fire_s  = (rep_key_s != 4'b0000) && (rep_key_s == rep_prev_q) &&
                    (rep_cnt_q == (rep_first_q ? DELAY_LAST : PERIOD_LAST));
      rep_prev_d  = rep_key_s;
      if ((rep_key_s == 4'b0000) || (rep_key_s != rep_prev_q)) begin
         rep_cnt_d   = '0;
         rep_first_d = 1'b1;
      end else if (rep_fire_s) begin
         rep_cnt_d   = '0;
         rep_first_d = 1'b0;
      end else begin
         rep_cnt_d   = rep_cnt_q + RCW'(1);
         rep_first_d = rep_first_q;
      end
      ev_s = press_s | (rep_fire_s ? rep_key_s : 4'b0000);
   end

   // Repeat timer state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rep_prev_q  <= 4'b0000;
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b1;
      end else begin
         rep_prev_q  <= rep_prev_d;
         rep_cnt_q   <= rep_cnt_d;
         rep_first_q <= rep_first_d;
      end
   end
`else
   assign ev_s = press_s;
`endif

   // Priority encode clr > add > sub > mul and compute the handshake next state
   always_comb begin
      any_ev_s = |ev_s;
      if (ev_s[0]) begin
         enc_op_s = 2'd0;
      end else if (ev_s[1]) begin
         enc_op_s = 2'd1;
      end else if (ev_s[2]) begin
         enc_op_s = 2'd2;
      end else begin
         enc_op_s = 2'd3;
      end
      accept_s    = cmd_valid_q & cmd_ready_i;
      op_cur_d    = accept_s ? cmd_op_q : op_cur_q;
      cmd_valid_d = cmd_valid_q;
      cmd_op_d    = cmd_op_q;
      if (any_ev_s) begin
         cmd_valid_d = 1'b1;
         cmd_op_d    = enc_op_s;
      end else if (accept_s) begin
         cmd_valid_d = 1'b0;
      end else begin
         cmd_valid_d = cmd_valid_q;
      end
      overrun_d = any_ev_s & cmd_valid_q & ~cmd_ready_i;
      multi_d   = multi_hot(ev_s);
   end

   // Synchronisers, debounce state and registered command outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q     <= 4'b0000;
         sync2_q     <= 4'b0000;
         key_state_q <= 4'b0000;
         key_prev_q  <= 4'b0000;
         for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
         cmd_valid_q <= 1'b0;
         cmd_op_q    <= 2'd0;
         op_cur_q    <= 2'd0;
         overrun_q   <= 1'b0;
         multi_q     <= 1'b0;
      end else begin
         sync1_q     <= raw_s;
         sync2_q     <= sync1_q;
         key_state_q <= key_state_d;
         key_prev_q  <= key_state_q;
         for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
         cmd_valid_q <= cmd_valid_d;
         cmd_op_q    <= cmd_op_d;
         op_cur_q    <= op_cur_d;
         overrun_q   <= overrun_d;
         multi_q     <= multi_d;
      end
   end

   assign cmd_valid_o = cmd_valid_q;
   assign cmd_op_o    = cmd_op_q;
   assign op_cur_o    = op_cur_q;
   assign key_state_o = key_state_q;
   assign overrun_o   = overrun_q;
   assign multi_o     = multi_q;

endmodule

// File: tb/tb_calc_key_frontend.sv
// Bench for calc_key_frontend: expected ops are queued as keys are driven and matched on every accepted command.
module tb_calc_key_frontend;

   logic       clk = 1'b0;
   logic       rst, key_clr, key_add, key_sub, key_mul, cmd_ready;
   logic       cmd_valid, overrun, multi;
   logic [1:0] cmd_op, op_cur;
   logic [3:0] key_state;

   logic [1:0] exp_q [$];
   logic [1:0] exp_op;
   int         n_vec = 0;
   int         n_err = 0;

   calc_key_frontend #(
      .DEB_CYCLES   (32'd4),
      .REPEAT_DELAY (32'd8),
      .REPEAT_PERIOD(32'd3)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .key_clr_i  (key_clr),
      .key_add_i  (key_add),
      .key_sub_i  (key_sub),
      .key_mul_i  (key_mul),
      .cmd_ready_i(cmd_ready),
      .cmd_valid_o(cmd_valid),
      .cmd_op_o   (cmd_op),
      .op_cur_o   (op_cur),
      .key_state_o(key_state),
      .overrun_o  (overrun),
      .multi_o    (multi)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(cmd_valid), 32'd0);
      check({tag, "_op"}, 32'(cmd_op), 32'd0);
      check({tag, "_opcur"}, 32'(op_cur), 32'd0);
      check({tag, "_ks"}, 32'(key_state), 32'd0);
      check({tag, "_ovr"}, 32'(overrun), 32'd0);
      check({tag, "_multi"}, 32'(multi), 32'd0);
   endtask

   // Scoreboard: every accepted command must match the oldest queued expectation
   always @(negedge clk) begin
      if (!rst && cmd_valid && cmd_ready) begin
         check("cmd_expected", 32'd1, 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            exp_op = exp_q.pop_front();
            check("cmd_op_accept", 32'(cmd_op), 32'(exp_op));
         end
      end
   end

   initial begin
      rst = 1'b1; key_clr = 1'b0; key_add = 1'b0; key_sub = 1'b0; key_mul = 1'b0; cmd_ready = 1'b0;
      ticks(2);
      check_all_zero("reset");
      rst = 1'b0;

      // Single add press with ready high
      cmd_ready = 1'b1; key_add = 1'b1; exp_q.push_back(2'd1);
      ticks(5);
      check("t1_ks_pre", 32'(key_state), 32'd0);
      tick();
      check("t1_ks", 32'(key_state), 32'h2);
      check("t1_valid_pre", 32'(cmd_valid), 32'd0);
      tick();
      check("t1_valid", 32'(cmd_valid), 32'd1);
      check("t1_op", 32'(cmd_op), 32'd1);
      check("t1_multi", 32'(multi), 32'd0);
      tick();
      check("t1_opcur", 32'(op_cur), 32'd1);
      check("t1_valid_drop", 32'(cmd_valid), 32'd0);
      key_add = 1'b0;
      ticks(8);
      check("t1_release_ks", 32'(key_state), 32'd0);
      check("t1_release_valid", 32'(cmd_valid), 32'd0);

      // Bounce shorter than the debounce window
      key_sub = 1'b1;
      ticks(3);
      key_sub = 1'b0;
      for (int t = 0; t < 12; t++) begin
         tick();
         check("t2_ks", 32'(key_state), 32'd0);
         check("t2_valid", 32'(cmd_valid), 32'd0);
      end
      check("t2_opcur_hold", 32'(op_cur), 32'd1);

      // Simultaneous clr + mul: clr wins
      exp_q.push_back(2'd0);
      key_clr = 1'b1; key_mul = 1'b1;
      ticks(6);
      check("t3_ks", 32'(key_state), 32'h9);
      tick();
      check("t3_valid", 32'(cmd_valid), 32'd1);
      check("t3_op", 32'(cmd_op), 32'd0);
      check("t3_multi", 32'(multi), 32'd1);
      tick();
      check("t3_multi_end", 32'(multi), 32'd0);
      check("t3_opcur", 32'(op_cur), 32'd0);
      check("t3_valid_drop", 32'(cmd_valid), 32'd0);
      key_clr = 1'b0; key_mul = 1'b0;
      for (int t = 0; t < 8; t++) begin
         tick();
         check("t3_no_mul", 32'(cmd_valid), 32'd0);
      end

      // Overrun: add pending, then mul overwrites it
      cmd_ready = 1'b0; key_add = 1'b1; exp_q.push_back(2'd3);
      ticks(7);
      check("t4_valid", 32'(cmd_valid), 32'd1);
      check("t4_op_add", 32'(cmd_op), 32'd1);
      check("t4_ovr_pre", 32'(overrun), 32'd0);
      key_add = 1'b0; key_mul = 1'b1;
      for (int t = 1; t <= 6; t++) begin
         tick();
         check("t4_hold_op", 32'(cmd_op), 32'd1);
         check("t4_hold_valid", 32'(cmd_valid), 32'd1);
         check("t4_hold_ovr", 32'(overrun), 32'd0);
      end
      tick();
      check("t4_op_mul", 32'(cmd_op), 32'd3);
      check("t4_ovr", 32'(overrun), 32'd1);
      check("t4_valid_kept", 32'(cmd_valid), 32'd1);
      key_mul = 1'b0;
      tick();
      check("t4_ovr_end", 32'(overrun), 32'd0);
      check("t4_opcur_pre", 32'(op_cur), 32'd0);
      check("t4_valid_wait", 32'(cmd_valid), 32'd1);
      cmd_ready = 1'b1;
      tick();
      check("t4_opcur", 32'(op_cur), 32'd3);
      check("t4_valid_drop", 32'(cmd_valid), 32'd0);
      ticks(8);

      // Reset while a command is pending and add is still held
      cmd_ready = 1'b0; key_add = 1'b1;
      ticks(7);
      check("t5_valid_pre", 32'(cmd_valid), 32'd1);
      rst = 1'b1;
      tick();
      check_all_zero("t5_rst");
      rst = 1'b0; exp_q.push_back(2'd1);
      for (int t = 1; t <= 7; t++) begin
         tick();
         check("t5_relatch", 32'(cmd_valid), 32'(t == 7));
      end
      check("t5_ks", 32'(key_state), 32'h2);
      cmd_ready = 1'b1;
      tick();
      check("t5_opcur", 32'(op_cur), 32'd1);
      key_add = 1'b0;
      ticks(8);

`ifdef KEY_REPEAT_EN
      // Auto-repeat of held mul: press, then +8, then every +3 until the debounced release
      key_mul = 1'b1;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if ((t == 7) || ((t >= 15) && (t <= 36) && (((t - 15) % 3) == 0))) begin
            exp_q.push_back(2'd3);
            check("rep_mul_valid", 32'(cmd_valid), 32'd1);
         end else begin
            check("rep_mul_valid", 32'(cmd_valid), 32'd0);
         end
         if (t == 30) key_mul = 1'b0;
      end
      ticks(4);
      key_clr = 1'b1; exp_q.push_back(2'd0);
      for (int t = 1; t <= 30; t++) begin
         tick();
         check("rep_clr_once", 32'(cmd_valid), 32'(t == 7));
      end
      key_clr = 1'b0;
      ticks(8);
`endif

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
